// File: rtl/mag_comp_arbiter_if.sv
// Request/response bundle between the requesting clients and the comparator arbiter.
// Latency: none, wires only.
// Backpressure: req_ready grants one requester per pulse; rsp_ready stalls the response.
//
// Ports (signals):
//   req_valid/req_a/req_b  per-requester operand pairs, requester i at slice [i*W +: W]
//   req_ready              one-hot grant pulse back to the requesters
//   rsp_valid/rsp_ready    response handshake
//   rsp_id, rsp_*          owner of the response and the captured comparator flags
// Modports: master = client side, slave = arbiter side.
interface mag_comp_arbiter_if #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_a_greater;
  logic              rsp_equal;
  logic              rsp_b_greater;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_a_greater, rsp_equal, rsp_b_greater
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_a_greater, rsp_equal, rsp_b_greater
  );
endinterface

// File: rtl/mag_comp_arbiter.sv
// Round-robin time-sharing of one magnitude comparator among NREQ requesters.
// Latency: grant to rsp_valid is 2 cycles; at most one request every 3 cycles.
// Backpressure: response held stable while rsp_ready is low; no grants until it is accepted.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   bus (slave)       request/response channels, see mag_comp_arbiter_if
//   cmp_a, cmp_b      registered operands driven to the shared comparator
//   cmp_equal, cmp_a_greater, cmp_b_greater   comparator flags, captured in CMP
//   busy              high whenever the FSM is not in IDLE
//   err               sticky flag-consistency error
// Optional feature: define MAG_COMP_ARB_CHECK_EN to build the one-hot flag check
// driving err; otherwise err is tied low.
module mag_comp_arbiter #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  mag_comp_arbiter_if.slave bus,
  output logic [W-1:0]      cmp_a,
  output logic [W-1:0]      cmp_b,
  input  logic              cmp_equal,
  input  logic              cmp_a_greater,
  input  logic              cmp_b_greater,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_a_greater_q;
  logic           rsp_equal_q;
  logic           rsp_b_greater_q;

  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan_idx;

  // Scan upward from rr_ptr; the IDW-bit add wraps modulo NREQ because NREQ
  // is a power of two.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = rr_ptr + IDW'(k);
      if (!grant_any && bus.req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Grant is only offered from IDLE, so a response handshake cycle never grants.
  assign bus.req_ready = (state == IDLE && grant_any) ? (NREQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      cmp_a           <= '0;
      cmp_b           <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_a_greater_q <= 1'b0;
      rsp_equal_q     <= 1'b0;
      rsp_b_greater_q <= 1'b0;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cmp_a    <= bus.req_a[int'(grant_idx)*W +: W];
            cmp_b    <= bus.req_b[int'(grant_idx)*W +: W];
            rsp_id_q <= grant_idx;
            rr_ptr   <= grant_idx + IDW'(1);
            busy     <= 1'b1;
            state    <= CMP;
          end
        end
        CMP: begin
          // Operands have been stable at the comparator for this whole cycle.
          rsp_a_greater_q <= cmp_a_greater;
          rsp_equal_q     <= cmp_equal;
          rsp_b_greater_q <= cmp_b_greater;
          rsp_valid_q     <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_a_greater = rsp_a_greater_q;
  assign bus.rsp_equal     = rsp_equal_q;
  assign bus.rsp_b_greater = rsp_b_greater_q;

`ifdef MAG_COMP_ARB_CHECK_EN
  logic       err_q;
  logic [2:0] flags;
  logic       flags_onehot;

  assign flags        = {cmp_a_greater, cmp_equal, cmp_b_greater};
  assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

  // Sticky until reset; the response itself still carries the raw flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == CMP && !flags_onehot) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mag_comp_arbiter.sv
// Directed bench for mag_comp_arbiter with a behavioural comparator model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: rsp_ready driven directly by the directed steps.
module tb_mag_comp_arbiter;
  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

`ifdef MAG_COMP_ARB_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] cmp_a;
  logic [W-1:0] cmp_b;
  logic         cmp_equal;
  logic         cmp_a_greater;
  logic         cmp_b_greater;
  logic         busy;
  logic         err;
  logic         force_bad;

  int checks = 0;
  int errors = 0;

  mag_comp_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus_if ();

  mag_comp_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if),
    .cmp_a         (cmp_a),
    .cmp_b         (cmp_b),
    .cmp_equal     (cmp_equal),
    .cmp_a_greater (cmp_a_greater),
    .cmp_b_greater (cmp_b_greater),
    .busy          (busy),
    .err           (err)
  );

  // Comparator model; force_bad injects the illegal pattern a_gt=0, eq=1, b_gt=1.
  assign cmp_a_greater = force_bad ? 1'b0 : (cmp_a > cmp_b);
  assign cmp_equal     = force_bad ? 1'b1 : (cmp_a == cmp_b);
  assign cmp_b_greater = force_bad ? 1'b1 : (cmp_a < cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rsp_flags();
    return {29'd0, bus_if.rsp_a_greater, bus_if.rsp_equal, bus_if.rsp_b_greater};
  endfunction

  // Operand table for the all-requesting round: 3<7, 9=9, 12>2, 5>4.
  logic [W-1:0] tab_a   [NREQ] = '{4'd3, 4'd9, 4'd12, 4'd5};
  logic [W-1:0] tab_b   [NREQ] = '{4'd7, 4'd9, 4'd2,  4'd4};
  logic [2:0]   tab_flg [NREQ] = '{3'b001, 3'b010, 3'b100, 3'b100};

  initial begin
    rst              = 1'b1;
    force_bad        = 1'b0;
    bus_if.req_valid = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.rsp_ready = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_req_ready", bus_if.req_ready, 0);
    chk("rst_rsp_valid", bus_if.rsp_valid, 0);
    chk("rst_rsp_id", bus_if.rsp_id, 0);
    chk("rst_rsp_flags", rsp_flags(), 0);
    chk("rst_cmp_a", cmp_a, 0);
    chk("rst_cmp_b", cmp_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // 1: single request, A=0 B=6, grant in cycle 0, response in cycle 2
    bus_if.req_a[0 +: W] = 4'd0;
    bus_if.req_b[0 +: W] = 4'd6;
    bus_if.req_valid     = 4'b0001;
    #1;
    chk("t1_grant", bus_if.req_ready, 32'b0001);
    chk("t1_idle_busy", busy, 0);
    cyc();
    bus_if.req_valid = '0;
    #1;
    chk("t1_cmp_busy", busy, 1);
    chk("t1_cmp_rsp_valid", bus_if.rsp_valid, 0);
    chk("t1_cmp_a", cmp_a, 0);
    chk("t1_cmp_b", cmp_b, 6);
    chk("t1_cmp_no_grant", bus_if.req_ready, 0);
    cyc();
    chk("t1_rsp_valid", bus_if.rsp_valid, 1);
    chk("t1_rsp_id", bus_if.rsp_id, 0);
    chk("t1_rsp_flags", rsp_flags(), 32'b001);
    bus_if.rsp_ready = 1'b1;
    cyc();
    bus_if.rsp_ready = 1'b0;
    chk("t1_done_valid", bus_if.rsp_valid, 0);
    chk("t1_done_busy", busy, 0);
    chk("t1_done_flags_hold", rsp_flags(), 32'b001);

    // 2: reset to clear rr_ptr, then all four request continuously
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus_if.req_a[i*W +: W] = tab_a[i];
      bus_if.req_b[i*W +: W] = tab_b[i];
    end
    bus_if.req_valid = 4'b1111;
    bus_if.rsp_ready = 1'b1;
    #1;
    for (int r = 0; r < 5; r++) begin
      int g;
      g = r % NREQ;
      chk("t2_grant", bus_if.req_ready, 32'd1 << g);
      cyc();
      chk("t2_cmp_a", cmp_a, tab_a[g]);
      chk("t2_cmp_b", cmp_b, tab_b[g]);
      cyc();
      chk("t2_rsp_valid", bus_if.rsp_valid, 1);
      chk("t2_rsp_id", bus_if.rsp_id, g);
      chk("t2_rsp_flags", rsp_flags(), tab_flg[g]);
      chk("t2_resp_no_grant", bus_if.req_ready, 0);
      cyc();
    end
    bus_if.req_valid = '0;
    bus_if.rsp_ready = 1'b0;
    #1;

    // 3: id2 A=12 B=6, response stalled 5 cycles with others pending (rr_ptr=1)
    bus_if.req_a[2*W +: W] = 4'd12;
    bus_if.req_b[2*W +: W] = 4'd6;
    bus_if.req_valid       = 4'b0100;
    #1;
    chk("t3_grant", bus_if.req_ready, 32'b0100);
    cyc();
    bus_if.req_valid = 4'b0011;
    #1;
    chk("t3_cmp_no_grant", bus_if.req_ready, 0);
    cyc();
    for (int s = 0; s < 5; s++) begin
      chk("t3_hold_valid", bus_if.rsp_valid, 1);
      chk("t3_hold_id", bus_if.rsp_id, 2);
      chk("t3_hold_flags", rsp_flags(), 32'b100);
      chk("t3_hold_cmp_a", cmp_a, 12);
      chk("t3_hold_no_grant", bus_if.req_ready, 0);
      cyc();
    end
    bus_if.rsp_ready = 1'b1;
    #1;
    chk("t3_accept_no_grant", bus_if.req_ready, 0);
    cyc();
    bus_if.rsp_ready = 1'b0;
    chk("t3_idle_valid", bus_if.rsp_valid, 0);
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_id_hold", bus_if.rsp_id, 2);
    // rr_ptr=3 and requesters 0,1 pending: scan wraps to 0
    chk("t3_wrap_grant", bus_if.req_ready, 32'b0001);
    bus_if.req_valid = '0;
    #1;
    chk("t3_withdraw", bus_if.req_ready, 0);
    cyc();
    chk("t3_withdraw_idle", busy, 0);

    // 4: id1 A=6 B=6 equal, then reset during RESP (rr_ptr was 3)
    bus_if.req_a[1*W +: W] = 4'd6;
    bus_if.req_b[1*W +: W] = 4'd6;
    bus_if.req_valid       = 4'b0010;
    #1;
    chk("t4_grant", bus_if.req_ready, 32'b0010);
    cyc();
    bus_if.req_valid = '0;
    cyc();
    chk("t4_rsp_valid", bus_if.rsp_valid, 1);
    chk("t4_rsp_id", bus_if.rsp_id, 1);
    chk("t4_rsp_flags", rsp_flags(), 32'b010);
    rst = 1'b1;
    cyc();
    chk("t4_rst_valid", bus_if.rsp_valid, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_id", bus_if.rsp_id, 0);
    chk("t4_rst_flags", rsp_flags(), 0);
    chk("t4_rst_cmp_a", cmp_a, 0);
    chk("t4_rst_cmp_b", cmp_b, 0);
    rst = 1'b0;
    bus_if.req_valid = 4'b1111;
    #1;
    chk("t4_rr_ptr_zero", bus_if.req_ready, 32'b0001);
    bus_if.req_valid = '0;
    #1;

    // 5: illegal flag pattern during CMP, err sticky until reset
    bus_if.req_a[0 +: W] = 4'd1;
    bus_if.req_b[0 +: W] = 4'd2;
    bus_if.req_valid     = 4'b0001;
    #1;
    chk("t5_grant", bus_if.req_ready, 32'b0001);
    cyc();
    bus_if.req_valid = '0;
    force_bad        = 1'b1;
    #1;
    chk("t5_cmp_err_pre", err, 0);
    cyc();
    force_bad = 1'b0;
    chk("t5_rsp_valid", bus_if.rsp_valid, 1);
    chk("t5_raw_flags", rsp_flags(), 32'b011);
    chk("t5_err", err, EXP_ERR);
    bus_if.rsp_ready = 1'b1;
    cyc();
    bus_if.rsp_ready = 1'b0;
    chk("t5_err_idle", err, EXP_ERR);
    // Good compare afterwards must not clear err (rr_ptr=1)
    bus_if.req_a[1*W +: W] = 4'd2;
    bus_if.req_b[1*W +: W] = 4'd1;
    bus_if.req_valid       = 4'b0010;
    #1;
    chk("t5_grant2", bus_if.req_ready, 32'b0010);
    cyc();
    bus_if.req_valid = '0;
    cyc();
    chk("t5_flags2", rsp_flags(), 32'b100);
    chk("t5_err_sticky", err, EXP_ERR);
    bus_if.rsp_ready = 1'b1;
    cyc();
    bus_if.rsp_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_err_cleared", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
